onehot_encoder: RTL and testbench
=================================

ONEHOT_ENCODER -- requirements
Module: onehot_encoder

Interface
REQ-001 SHALL have parameter IN_W, default 16, width of the one-hot input vector.
REQ-002 SHALL have parameter OUT_W, default 4, width of the binary index; SHALL equal clog2(IN_W).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream has a code on one_hot.
REQ-006 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port one_hot  input  IN_W  code to encode.
REQ-008 SHALL have port out_valid  output  1  binary/out_err hold a result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 SHALL have port binary  output  OUT_W  encoded index.
REQ-011 SHALL have port out_err  output  1  result came from an illegal code (zero or multi-hot).
REQ-012 SHALL have port clear_count  input  1  synchronous clear of err_count.
REQ-013 SHALL have port err_count  output  8  saturating count of accepted illegal codes.

Function
REQ-014 SHALL accept an input only when in_valid and in_ready are both 1 on a rising edge.
REQ-015 SHALL deliver a result only when out_valid and out_ready are both 1 on a rising edge.
REQ-016 SHALL buffer results in a 2-entry in-order FIFO with states EMPTY, ONE, FULL.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only.
REQ-018 SHALL drive out_valid = 1 in ONE and FULL and 0 in EMPTY.
REQ-019 SHALL present an accepted code on binary/out_err in the cycle after acceptance when the FIFO was EMPTY; minimum latency 1 cycle.
REQ-020 SHALL take these state transitions: EMPTY -> ONE on accept; ONE -> FULL on accept without deliver; ONE -> EMPTY on deliver without accept; ONE -> ONE on simultaneous accept and deliver; FULL -> ONE on deliver. No other transitions are permitted.
REQ-021 SHALL encode an exactly-one-hot code with bit k set as binary = k and out_err = 0.
REQ-022 SHALL encode a multi-hot code as binary = index of the lowest set bit and out_err = 1.
REQ-023 SHALL encode an all-zero code as binary = 0 and out_err = 1.
REQ-024 SHALL hold binary and out_err stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL register one_hot at acceptance; later changes to one_hot SHALL NOT affect buffered results.
REQ-026 SHALL increment err_count by 1 on each accepted code with out_err = 1, at acceptance.
REQ-027 SHALL saturate err_count at 255.
REQ-028 SHALL set err_count to 0 on clear_count = 1; clear SHALL take precedence over a same-cycle increment.
REQ-029 SHALL ignore one_hot and in_valid while in_ready = 0; no state or counter change.

Reset
REQ-030 SHALL, on rst_n = 0, immediately and without clock: set state EMPTY, out_valid = 0, in_ready = 1, binary = 0, out_err = 0, err_count = 0.
REQ-031 SHALL discard all buffered results when reset is asserted mid-operation.
REQ-032 SHALL accept a code on the first rising edge after rst_n deasserts.

Verification
REQ-033 Bench SHALL drive one_hot = 16'h0020, in_valid = 1, out_ready = 1 -> next cycle out_valid = 1, binary = 5, out_err = 0, err_count = 0.
REQ-034 Bench SHALL hold out_ready = 0 and offer 16'h0001, 16'h8000, 16'h0004 on consecutive cycles -> first two accepted, in_ready = 0 on the third; after out_ready = 1, outputs are 0 then 15 then 2, in order.
REQ-035 Bench SHALL offer 16'h0000 then 16'h0050 -> outputs binary = 0/out_err = 1, then binary = 4/out_err = 1; err_count = 2.
REQ-036 Bench SHALL stream 300 illegal codes -> err_count = 255; then clear_count = 1 together with another illegal accept -> err_count = 0.
REQ-037 Bench SHALL fill the FIFO to FULL, then pulse rst_n = 0 between clock edges -> out_valid = 0, in_ready = 1, err_count = 0 at once, with no stale result after release.
REQ-038 Bench SHALL, in state ONE, accept 16'h0100 while delivering -> state stays ONE, next output binary = 8.

Source files
------------

// File: rtl/onehot_encoder_if.sv
// Valid/ready bundle for the one-hot encoder: code in on one side, index/error out on the other.
interface onehot_encoder_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = $clog2(IN_W)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  one_hot;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] binary;
  logic             out_err;

  modport master (
    output in_valid, one_hot, out_ready,
    input  in_ready, out_valid, binary, out_err
  );

  modport slave (
    input  in_valid, one_hot, out_ready,
    output in_ready, out_valid, binary, out_err
  );
endinterface

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder with a 2-entry result FIFO and a saturating illegal-code counter.
module onehot_encoder #(
  parameter int IN_W  = 16,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  onehot_encoder_if.slave   bus,
  input  logic              clear_count,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic             accept, deliver;
  logic             load_new, load_tail, shift_tail;
  logic [OUT_W:0]   enc, head, tail;

  // Result packed as {err, index}; the lowest set bit wins for multi-hot codes.
  function automatic logic [OUT_W:0] encode(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] idx;
    logic             err;
    idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (code[i]) idx = OUT_W'(i);
    end
    err = (code == '0) || ((code & (code - IN_W'(1))) != '0);
    return {err, idx};
  endfunction

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.binary    = head[OUT_W-1:0];
  assign bus.out_err   = head[OUT_W];

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;
  assign enc     = encode(bus.one_hot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_new   = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_new  = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_new = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_tail = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_nxt  = ONE;
          shift_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // head is the presented result, so it is reset to give binary = 0 / out_err = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          head <= '0;
    else if (load_new)   head <= enc;
    else if (shift_tail) head <= tail;
  end

  always_ff @(posedge clk) begin
    if (load_tail) tail <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_count <= 8'd0;
    else if (clear_count)                          err_count <= 8'd0;
    else if (accept && enc[OUT_W] && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_onehot_encoder.sv
// Scoreboard bench for onehot_encoder: driver queues expected results, monitor checks deliveries.
module tb_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_count = 1'b0;
  logic [7:0] err_count;
  int         tests = 0;
  int         fails = 0;
  logic [4:0] exp_q[$];

  onehot_encoder_if #(.IN_W(16), .OUT_W(4)) bus ();

  onehot_encoder #(.IN_W(16), .OUT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_count (clear_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every delivery handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got bin=%0d err=%0b, want no output", bus.binary, bus.out_err);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({bus.out_err, bus.binary} != e) begin
          fails++;
          $display("FAIL out_data: got bin=%0d err=%0b, want bin=%0d err=%0b",
                   bus.binary, bus.out_err, e[3:0], e[4]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] code, input logic [3:0] eb, input logic ee);
    int n = 0;
    bus.one_hot  = code;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 for code %h, want 1", code);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back({ee, eb});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.one_hot   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_binary",    bus.binary, 0);
    chk("rst_out_err",   bus.out_err, 0);
    chk("rst_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single legal code, latency 1
    bus.out_ready = 1'b1;
    send(16'h0020, 4'd5, 1'b0);
    chk("lat_out_valid", bus.out_valid, 1);
    chk("lat_binary",    bus.binary, 5);
    chk("lat_out_err",   bus.out_err, 0);
    chk("lat_err_count", err_count, 0);
    drain();

    // Backpressure: fill FIFO, third code must wait
    bus.out_ready = 1'b0;
    send(16'h0001, 4'd0, 1'b0);
    send(16'h8000, 4'd15, 1'b0);
    bus.one_hot  = 16'h0004;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    chk("full_in_ready_hold", bus.in_ready, 0);
    chk("full_binary_hold",   bus.binary, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h0004, 4'd2, 1'b0);
    drain();

    // Illegal codes: zero and multi-hot
    send(16'h0000, 4'd0, 1'b1);
    send(16'h0050, 4'd4, 1'b1);
    drain();
    chk("err_count_two", err_count, 2);

    // Saturation, then clear beating a simultaneous increment
    for (int i = 0; i < 300; i++) send(16'h0003, 4'd0, 1'b1);
    drain();
    chk("err_count_sat", err_count, 255);
    clear_count = 1'b1;
    send(16'hFFFF, 4'd0, 1'b1);
    clear_count = 1'b0;
    chk("err_count_clear", err_count, 0);
    drain();

    // Accept while delivering in ONE
    bus.out_ready = 1'b0;
    send(16'h0200, 4'd9, 1'b0);
    bus.out_ready = 1'b1;
    send(16'h0100, 4'd8, 1'b0);
    chk("one_out_valid", bus.out_valid, 1);
    chk("one_in_ready",  bus.in_ready, 1);
    chk("one_binary",    bus.binary, 8);
    drain();

    // Fill, ignore offers while FULL, then async reset mid-cycle
    bus.out_ready = 1'b0;
    send(16'h0002, 4'd1, 1'b0);
    send(16'h0000, 4'd0, 1'b1);
    chk("fill_err_count", err_count, 1);
    bus.one_hot  = 16'h0000;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ignored_err_count", err_count, 1);
    chk("ignored_in_ready",  bus.in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_in_ready",  bus.in_ready, 1);
    chk("async_err_count", err_count, 0);
    chk("async_binary",    bus.binary, 0);
    chk("async_out_err",   bus.out_err, 0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.one_hot   = 16'h0008;
    bus.in_valid  = 1'b1;
    exp_q.push_back({1'b0, 4'd3});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("post_rst_out_valid", bus.out_valid, 1);
    chk("post_rst_binary",    bus.binary, 3);
    drain();
    chk("no_stale_out_valid", bus.out_valid, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
